anabellek_hakemi: RTL and testbench

- Arbiter and sequencer for the single main-memory port.
- Shares the port between two requesters:
  - the instruction-cache controller in the fetch stage (read-only, 128-bit line fills);
  - the data-cache controller in the memory stage (line reads and write-backs).
- Serialises one transaction at a time, holds the request stable until memory accepts it, and routes the returned line and completion pulse back to the owner.

---
 rtl/anabellek_hakemi.sv | 147 ++++++++++++++
 tb/tb_anabellek_hakemi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/anabellek_hakemi.sv
// Main-memory port arbiter: serialises fetch line fills and data-side reads/write-backs.
// Optional fetch anti-starvation counter enabled by defining HAKEM_ACLIK_SAYACI_EN.
module anabellek_hakemi #(
  parameter int ADRES_BIT   = 32,
  parameter int OBEK_BIT    = 128,
  parameter int ACLIK_ESIGI = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 getir_istek_i,
  input  logic [ADRES_BIT-1:0] getir_adres_i,
  output logic                 getir_musait_o,
  output logic                 getir_veri_hazir_o,
  output logic [OBEK_BIT-1:0]  getir_obek_o,
  input  logic                 bellek_istek_i,
  input  logic [ADRES_BIT-1:0] bellek_adres_i,
  input  logic                 bellek_oku_i,
  input  logic                 bellek_yaz_i,
  input  logic [OBEK_BIT-1:0]  bellek_yaz_obek_i,
  output logic                 bellek_musait_o,
  output logic                 bellek_veri_hazir_o,
  output logic [OBEK_BIT-1:0]  bellek_obek_o,
  output logic                 anabellek_istek_o,
  output logic [ADRES_BIT-1:0] anabellek_adres_o,
  output logic                 anabellek_oku_o,
  output logic                 anabellek_yaz_o,
  output logic [OBEK_BIT-1:0]  anabellek_yaz_obek_o,
  input  logic                 anabellek_kabul_i,
  input  logic                 anabellek_veri_gecerli_i,
  input  logic [OBEK_BIT-1:0]  anabellek_okunan_obek_i
);

  typedef enum logic [1:0] {BOSTA, ISTEK, BEKLE, YANIT} durum_t;

  durum_t                durum_q, durum_d;
  logic                  sahip_getir_q, sahip_getir_d;
  logic [ADRES_BIT-1:0]  adres_q, adres_d;
  logic                  oku_q, oku_d, yaz_q, yaz_d;
  logic [OBEK_BIT-1:0]   yaz_obek_q, yaz_obek_d;
  logic [OBEK_BIT-1:0]   getir_obek_q, getir_obek_d;
  logic [OBEK_BIT-1:0]   bellek_obek_q, bellek_obek_d;
  logic                  bellek_gecerli, getir_sec, yakala;
  logic                  unused_bitler;

  // A data request without a command is not a request at all.
  assign bellek_gecerli = bellek_istek_i & (bellek_oku_i | bellek_yaz_i);
  assign unused_bitler  = ^{getir_adres_i[3:0], bellek_adres_i[3:0], ACLIK_ESIGI[0]};

`ifdef HAKEM_ACLIK_SAYACI_EN
  logic [2:0] sayac_q, sayac_d;

  assign getir_sec = getir_istek_i & (~bellek_gecerli | (sayac_q == 3'(ACLIK_ESIGI)));

  always_comb begin
    sayac_d = sayac_q;
    if (durum_q == BOSTA) begin
      if (getir_sec) sayac_d = '0;
      else if (bellek_gecerli && getir_istek_i && sayac_q != 3'd7) sayac_d = sayac_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sayac_q <= '0;
    else        sayac_q <= sayac_d;
  end
`else
  assign getir_sec = getir_istek_i & ~bellek_gecerli;
`endif

  // Returned line is taken either on the combined accept+valid cycle or while waiting.
  assign yakala = ((durum_q == ISTEK) && anabellek_kabul_i && anabellek_veri_gecerli_i) ||
                  ((durum_q == BEKLE) && anabellek_veri_gecerli_i);

  always_comb begin
    durum_d       = durum_q;
    sahip_getir_d = sahip_getir_q;
    adres_d       = adres_q;
    oku_d         = oku_q;
    yaz_d         = yaz_q;
    yaz_obek_d    = yaz_obek_q;
    getir_obek_d  = getir_obek_q;
    bellek_obek_d = bellek_obek_q;
    case (durum_q)
      BOSTA: begin
        if (getir_sec) begin
          sahip_getir_d = 1'b1;
          adres_d       = {getir_adres_i[ADRES_BIT-1:4], 4'h0};
          oku_d         = 1'b1;
          yaz_d         = 1'b0;
          yaz_obek_d    = '0;
          durum_d       = ISTEK;
        end else if (bellek_gecerli) begin
          sahip_getir_d = 1'b0;
          adres_d       = {bellek_adres_i[ADRES_BIT-1:4], 4'h0};
          oku_d         = ~bellek_yaz_i;
          yaz_d         = bellek_yaz_i;
          yaz_obek_d    = bellek_yaz_obek_i;
          durum_d       = ISTEK;
        end
      end
      ISTEK: if (anabellek_kabul_i) durum_d = anabellek_veri_gecerli_i ? YANIT : BEKLE;
      BEKLE: if (anabellek_veri_gecerli_i) durum_d = YANIT;
      YANIT: durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
    if (yakala && oku_q) begin
      if (sahip_getir_q) getir_obek_d  = anabellek_okunan_obek_i;
      else               bellek_obek_d = anabellek_okunan_obek_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q       <= BOSTA;
      sahip_getir_q <= 1'b0;
      adres_q       <= '0;
      oku_q         <= 1'b0;
      yaz_q         <= 1'b0;
      yaz_obek_q    <= '0;
      getir_obek_q  <= '0;
      bellek_obek_q <= '0;
    end else begin
      durum_q       <= durum_d;
      sahip_getir_q <= sahip_getir_d;
      adres_q       <= adres_d;
      oku_q         <= oku_d;
      yaz_q         <= yaz_d;
      yaz_obek_q    <= yaz_obek_d;
      getir_obek_q  <= getir_obek_d;
      bellek_obek_q <= bellek_obek_d;
    end
  end

  // Idle flags are forced low while reset is held so every output reads 0 then.
  assign getir_musait_o       = rst_i & (durum_q == BOSTA);
  assign bellek_musait_o      = rst_i & (durum_q == BOSTA);
  assign getir_veri_hazir_o   = (durum_q == YANIT) &  sahip_getir_q;
  assign bellek_veri_hazir_o  = (durum_q == YANIT) & ~sahip_getir_q;
  assign getir_obek_o         = getir_obek_q;
  assign bellek_obek_o        = bellek_obek_q;
  assign anabellek_istek_o    = (durum_q == ISTEK);
  assign anabellek_adres_o    = adres_q;
  assign anabellek_oku_o      = oku_q;
  assign anabellek_yaz_o      = yaz_q;
  assign anabellek_yaz_obek_o = yaz_obek_q;

endmodule

// File: tb/tb_anabellek_hakemi.sv
// Random two-requester traffic plus a random memory, scored against a transaction-level model.
module tb_anabellek_hakemi;
  logic         clk_i = 1'b0, rst_i = 1'b0;
  logic         getir_istek_i, getir_musait_o, getir_veri_hazir_o;
  logic [31:0]  getir_adres_i;
  logic [127:0] getir_obek_o;
  logic         bellek_istek_i, bellek_oku_i, bellek_yaz_i, bellek_musait_o, bellek_veri_hazir_o;
  logic [31:0]  bellek_adres_i;
  logic [127:0] bellek_yaz_obek_i, bellek_obek_o;
  logic         anabellek_istek_o, anabellek_oku_o, anabellek_yaz_o;
  logic [31:0]  anabellek_adres_o;
  logic [127:0] anabellek_yaz_obek_o, anabellek_okunan_obek_i;
  logic         anabellek_kabul_i, anabellek_veri_gecerli_i;

  always #5 clk_i = ~clk_i;

  anabellek_hakemi dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .getir_istek_i(getir_istek_i), .getir_adres_i(getir_adres_i),
    .getir_musait_o(getir_musait_o), .getir_veri_hazir_o(getir_veri_hazir_o),
    .getir_obek_o(getir_obek_o),
    .bellek_istek_i(bellek_istek_i), .bellek_adres_i(bellek_adres_i),
    .bellek_oku_i(bellek_oku_i), .bellek_yaz_i(bellek_yaz_i),
    .bellek_yaz_obek_i(bellek_yaz_obek_i), .bellek_musait_o(bellek_musait_o),
    .bellek_veri_hazir_o(bellek_veri_hazir_o), .bellek_obek_o(bellek_obek_o),
    .anabellek_istek_o(anabellek_istek_o), .anabellek_adres_o(anabellek_adres_o),
    .anabellek_oku_o(anabellek_oku_o), .anabellek_yaz_o(anabellek_yaz_o),
    .anabellek_yaz_obek_o(anabellek_yaz_obek_o), .anabellek_kabul_i(anabellek_kabul_i),
    .anabellek_veri_gecerli_i(anabellek_veri_gecerli_i),
    .anabellek_okunan_obek_i(anabellek_okunan_obek_i)
  );

  int total = 0, bad = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: the one transaction in flight, plus the lines each owner should be showing.
  bit           t_val, t_fetch, t_oku, t_yaz, t_acc, t_done;
  logic [31:0]  t_adr;
  logic [127:0] t_line, g_exp, b_exp;
  int           cnt;
  // Requester bookkeeping
  bit           g_pend, g_drop, d_pend, d_drop;
  bit           starve, did_rst;
  int           starve_g;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    t_val = 0; t_done = 0; t_acc = 0; t_fetch = 0; t_oku = 0; t_yaz = 0;
    t_adr = '0; t_line = '0; g_exp = '0; b_exp = '0; cnt = 0;
    g_pend = 0; g_drop = 0; d_pend = 0; d_drop = 0;
  endtask

  task automatic capture();
    t_done = 1;
    if (t_fetch) g_exp = anabellek_okunan_obek_i;
    else if (t_oku) b_exp = anabellek_okunan_obek_i;
  endtask

  // Advance the model across one rising edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit dv, gsel;
    dv = bellek_istek_i && (bellek_oku_i || bellek_yaz_i);
`ifdef HAKEM_ACLIK_SAYACI_EN
    gsel = getir_istek_i && (!dv || cnt == 4);
`else
    gsel = getir_istek_i && !dv;
`endif
    if (t_val && t_done) begin
      t_val = 0; t_done = 0;
    end else if (!t_val) begin
      t_acc = 0; t_done = 0;
      if (gsel) begin
        t_val = 1; t_fetch = 1; t_adr = getir_adres_i & ~32'hF; t_oku = 1; t_yaz = 0; cnt = 0;
      end else if (dv) begin
        t_val = 1; t_fetch = 0; t_adr = bellek_adres_i & ~32'hF;
        t_yaz = bellek_yaz_i; t_oku = !bellek_yaz_i; t_line = bellek_yaz_obek_i;
        if (getir_istek_i && cnt < 7) cnt++;
      end
    end else if (!t_acc) begin
      if (anabellek_kabul_i) begin
        t_acc = 1;
        if (anabellek_veri_gecerli_i) capture();
      end
    end else if (anabellek_veri_gecerli_i) begin
      capture();
    end
  endtask

  task automatic check_outputs();
    chk("getir_musait", getir_musait_o, !t_val);
    chk("bellek_musait", bellek_musait_o, !t_val);
    chk("mem_istek", anabellek_istek_o, t_val && !t_acc);
    if (t_val && !t_acc) begin
      chk("mem_adres", anabellek_adres_o, t_adr);
      chk("mem_oku", anabellek_oku_o, t_oku);
      chk("mem_yaz", anabellek_yaz_o, t_yaz);
      if (t_yaz) chk("mem_yaz_obek", anabellek_yaz_obek_o, t_line);
    end
    chk("getir_hazir", getir_veri_hazir_o, t_val && t_done && t_fetch);
    chk("bellek_hazir", bellek_veri_hazir_o, t_val && t_done && !t_fetch);
    chk("getir_obek", getir_obek_o, g_exp);
    chk("bellek_obek", bellek_obek_o, b_exp);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_getir_musait"}, getir_musait_o, 0);
    chk({tag, "_bellek_musait"}, bellek_musait_o, 0);
    chk({tag, "_getir_hazir"}, getir_veri_hazir_o, 0);
    chk({tag, "_bellek_hazir"}, bellek_veri_hazir_o, 0);
    chk({tag, "_getir_obek"}, getir_obek_o, 0);
    chk({tag, "_bellek_obek"}, bellek_obek_o, 0);
    chk({tag, "_mem_istek"}, anabellek_istek_o, 0);
    chk({tag, "_mem_adres"}, anabellek_adres_o, 0);
    chk({tag, "_mem_oku"}, anabellek_oku_o, 0);
    chk({tag, "_mem_yaz"}, anabellek_yaz_o, 0);
    chk({tag, "_mem_yaz_obek"}, anabellek_yaz_obek_o, 0);
  endtask

  // Choose requester and memory inputs for the next edge.
  task automatic drive(bit hep);
    int r;
    anabellek_kabul_i        = ($urandom() % 2) == 0;
    anabellek_veri_gecerli_i = ($urandom() % 3) == 0;
    anabellek_okunan_obek_i  = rnd128();
    if (t_val && t_done && t_fetch)  g_pend = 0;
    if (t_val && t_done && !t_fetch) d_pend = 0;
    if (g_pend && t_val && t_fetch && !g_drop && ($urandom() % 8) == 0) g_drop = 1;
    if (d_pend && t_val && !t_fetch && !d_drop && ($urandom() % 8) == 0) d_drop = 1;
    if (!g_pend && (hep || ($urandom() % 4) == 0)) begin
      g_pend = 1; g_drop = 0; getir_adres_i = $urandom();
    end
    getir_istek_i = g_pend && !g_drop;
    if (!d_pend && (hep || ($urandom() % 4) == 0)) begin
      d_pend = 1; d_drop = 0; bellek_adres_i = $urandom();
      r = int'($urandom() % 3);
      bellek_oku_i = (r != 1); bellek_yaz_i = (r != 0); bellek_yaz_obek_i = rnd128();
    end
    if (d_pend) bellek_istek_i = !d_drop;
    else if (($urandom() % 16) == 0) begin
      bellek_istek_i = 1; bellek_oku_i = 0; bellek_yaz_i = 0;
    end else bellek_istek_i = 0;
  endtask

  initial begin
    getir_istek_i = 0; getir_adres_i = '0; bellek_istek_i = 0; bellek_adres_i = '0;
    bellek_oku_i = 0; bellek_yaz_i = 0; bellek_yaz_obek_i = '0; anabellek_kabul_i = 0;
    anabellek_veri_gecerli_i = 1; anabellek_okunan_obek_i = '1;
    model_reset(); did_rst = 0; starve_g = 0; starve = 0;
    repeat (3) @(posedge clk_i);
    #1 check_zero("rst0");
    rst_i = 1;
    drive(0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      model_edge();
      check_outputs();
      starve = (c >= 1500 && c < 1800);
      if (c >= 1600 && c < 1800 && getir_veri_hazir_o) starve_g++;
      if (!did_rst && c >= 400 && t_val && t_acc && !t_done) begin
        #1 rst_i = 0; anabellek_veri_gecerli_i = 1;
        #1 check_zero("rst_bekle");
        @(posedge clk_i); #1 check_zero("rst_hold");
        rst_i = 1; did_rst = 1; model_reset();
      end
      drive(starve);
    end
    chk("rst_bekle_hit", did_rst, 1);
`ifdef HAKEM_ACLIK_SAYACI_EN
    chk("starve_getir_seen", starve_g != 0, 1);
`else
    chk("starve_getir", starve_g, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
